accum_rate_sampler: RTL and testbench

Downstream consumer of the 32-bit accumulator's `sum` output. Samples `sum` every `PERIOD` cycles, computes the modular increment since the previous sample, tags it against a programmable threshold and queues it in a small FIFO drained over a valid/ready handshake. Turns the free-running running total into a stream of per-window rate reports for software or a later stage.

---
 rtl/accum_rate_sampler.sv | 138 +++++++++++++
 tb/tb_accum_rate_sampler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_rate_sampler.sv
// accum_rate_sampler
//
// Samples an accumulator's running total every PERIOD cycles. It computes
// the modular increment since the previous sample and tags it when it
// exceeds a threshold. Each report goes into a small FIFO that a consumer
// drains over a valid/ready handshake.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low; clears all state while low
//   sum          accumulator running total
//   enable       sampling enable; dropping it forces a re-prime
//   thresh       unsigned threshold, captured on the sample edge
//   ready        consumer accepts the head entry
//   clr_ovf      clears the sticky overflow flag
//   delta        head entry increment (0 when FIFO empty)
//   over_thresh  head entry flag: delta > thresh (0 when FIFO empty)
//   valid        FIFO non-empty
//   count        FIFO occupancy
//   overflow     sticky: a report was dropped because the FIFO was full
module accum_rate_sampler #(
    parameter int WIDTH  = 32,
    parameter int PERIOD = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           sum,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           thresh,
    input  logic                       ready,
    input  logic                       clr_ovf,
    output logic [WIDTH-1:0]           delta,
    output logic                       over_thresh,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int CW   = $clog2(PERIOD);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   prev_reg;
    logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNTW-1:0]    count_reg;
    logic               overflow_reg;
    logic [WIDTH:0]     mem [DEPTH];

    logic               strobe;
    logic               push, pop, full, wr_en;
    logic [WIDTH-1:0]   delta_new;
    logic               over_new;
    logic [WIDTH:0]     head;

    // The strobe is gated by enable, so an edge that drops enable never
    // samples or pushes.
    assign strobe    = enable && (state_reg != IDLE) && (cnt_reg == CW'(PERIOD-1));
    assign push      = strobe && (state_reg == RUN);
    // Modular subtraction gives the true increment across a wrap of sum.
    assign delta_new = sum - prev_reg;
    assign over_new  = (delta_new > thresh);

    assign valid = (count_reg != '0);
    assign full  = (count_reg == CNTW'(DEPTH));
    assign pop   = valid && ready;
    // When full, a pop on the same edge frees the slot the push writes into.
    assign wr_en = push && (!full || pop);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = PRIME;
            PRIME:   if (!enable) state_next = IDLE;
                     else if (strobe) state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            prev_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE || !enable || strobe)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + CW'(1);
            if (strobe)
                prev_reg <= sum;
        end
    end

    // Storage is not reset: entries are only visible through the
    // occupancy count, which is reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= {over_new, delta_new};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + CNTW'(1);
                2'b01:   count_reg <= count_reg - CNTW'(1);
                default: count_reg <= count_reg;
            endcase
            // A drop on the same edge as clr_ovf keeps the flag set.
            if (push && full && !pop)
                overflow_reg <= 1'b1;
            else if (clr_ovf)
                overflow_reg <= 1'b0;
        end
    end

    assign head        = mem[rd_ptr_reg];
    assign delta       = valid ? head[WIDTH-1:0] : '0;
    assign over_thresh = valid ? head[WIDTH] : 1'b0;
    assign count       = count_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_accum_rate_sampler.sv
module tb_accum_rate_sampler;

    localparam int WIDTH  = 32;
    localparam int PERIOD = 4;
    localparam int DEPTH  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] sum;
    logic             enable;
    logic [WIDTH-1:0] thresh;
    logic             ready;
    logic             clr_ovf;
    logic [WIDTH-1:0] delta;
    logic             over_thresh;
    logic             valid;
    logic [2:0]       count;
    logic             overflow;

    logic [WIDTH-1:0] sum_step;
    int               checks = 0;
    int               errors = 0;

    accum_rate_sampler #(.WIDTH(WIDTH), .PERIOD(PERIOD), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sum(sum), .enable(enable), .thresh(thresh),
        .ready(ready), .clr_ovf(clr_ovf), .delta(delta), .over_thresh(over_thresh),
        .valid(valid), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // One clock: wait for the edge, let outputs settle, then advance sum.
    task automatic step_cycle();
        @(posedge clk);
        #1;
        sum = sum + sum_step;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        ready  = 1'b1;
        for (int i = 0; i < 6; i++) step_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; ready = 1'b0; clr_ovf = 1'b0;
        sum = '0; sum_step = '0; thresh = '0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || count !== 3'd0 || delta !== '0 || over_thresh !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b count=%0d delta=%h over=%b ovf=%b, required all 0",
                     valid, count, delta, over_thresh, overflow);
        end
        for (int i = 0; i < 2; i++) step_cycle();
        #2 reset = 1'b1;
        step_cycle();
        $display("test_reset: done");
    endtask

    task automatic test_ramp();
        sum = 32'd100; sum_step = 32'd1; thresh = 32'd4; ready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) step_cycle();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL ramp_no_early_valid: valid=%b required 0", valid);
        end
        step_cycle();
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (valid !== 1'b1 || delta !== 32'd4 || over_thresh !== 1'b0 || count !== 3'd1) begin
                errors++;
                $display("FAIL ramp_report%0d: valid=%b delta=%0d over=%b count=%0d required 1/4/0/1",
                         r, valid, delta, over_thresh, count);
            end
            for (int i = 0; i < 3; i++) step_cycle();
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL ramp_gap%0d: valid=%b required 0", r, valid);
            end
            step_cycle();
        end
        $display("test_ramp: done");
    endtask

    task automatic test_threshold();
        go_idle();
        sum_step = 32'd2; thresh = 32'd4;
        enable = 1'b1;
        for (int i = 0; i < 9; i++) step_cycle();
        for (int r = 0; r < 2; r++) begin
            checks++;
            if (valid !== 1'b1 || delta !== 32'd8 || over_thresh !== 1'b1) begin
                errors++;
                $display("FAIL thresh4_report%0d: valid=%b delta=%0d over=%b required 1/8/1",
                         r, valid, delta, over_thresh);
            end
            for (int i = 0; i < 4; i++) step_cycle();
        end
        // Equal to threshold: strict compare must clear the flag.
        thresh = 32'd8;
        for (int i = 0; i < 4; i++) step_cycle();
        checks++;
        if (valid !== 1'b1 || delta !== 32'd8 || over_thresh !== 1'b0) begin
            errors++;
            $display("FAIL thresh8_equal: valid=%b delta=%0d over=%b required 1/8/0",
                     valid, delta, over_thresh);
        end
        $display("test_threshold: done");
    endtask

    task automatic test_wrap();
        go_idle();
        sum = 32'hFFFF_FFF0; sum_step = 32'd1; thresh = 32'd4;
        enable = 1'b1;
        for (int i = 0; i < 9; i++) step_cycle();
        for (int r = 0; r < 5; r++) begin
            checks++;
            if (valid !== 1'b1 || delta !== 32'd4 || over_thresh !== 1'b0) begin
                errors++;
                $display("FAIL wrap_report%0d: valid=%b delta=%h over=%b required 1/4/0",
                         r, valid, delta, over_thresh);
            end
            for (int i = 0; i < 4; i++) step_cycle();
        end
        $display("test_wrap: done");
    endtask

    task automatic test_backpressure();
        go_idle();
        ready = 1'b0; thresh = 32'd100; sum_step = '0;
        enable = 1'b1;
        // Step grows by one each window so queued deltas are 4, 8, 12, 16
        // and the fifth (20) is dropped.
        for (int j = 1; j <= 25; j++) begin
            sum_step = 32'((j - 1) / 4);
            step_cycle();
            if (j == 21) begin
                checks++;
                if (count !== 3'd4 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full: count=%0d ovf=%b required 4/0", count, overflow);
                end
            end
        end
        checks++;
        if (count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_drop: count=%0d ovf=%b required 4/1", count, overflow);
        end
        enable = 1'b0; ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (valid !== 1'b1 || delta !== 32'(4 * (k + 1))) begin
                errors++;
                $display("FAIL bp_drain%0d: valid=%b delta=%0d required 1/%0d",
                         k, valid, delta, 4 * (k + 1));
            end
            step_cycle();
        end
        checks++;
        if (count !== 3'd0 || valid !== 1'b0 || delta !== '0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_empty: count=%0d valid=%b delta=%0d ovf=%b required 0/0/0/1",
                     count, valid, delta, overflow);
        end
        clr_ovf = 1'b1;
        step_cycle();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_clr_ovf: ovf=%b required 0", overflow);
        end
        $display("test_backpressure: done");
    endtask

    task automatic test_async_reset();
        go_idle();
        ready = 1'b0; thresh = '0; sum_step = 32'd1;
        enable = 1'b1;
        for (int i = 0; i < 13; i++) step_cycle();
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL ar_pre_count: count=%0d required 2", count);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 || delta !== '0) begin
            errors++;
            $display("FAIL ar_immediate: valid=%b count=%0d ovf=%b delta=%0d required all 0",
                     valid, count, overflow, delta);
        end
        enable = 1'b0; ready = 1'b1;
        #3 reset = 1'b1;
        step_cycle();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) step_cycle();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_reprime: valid=%b required 0", valid);
        end
        step_cycle();
        checks++;
        if (valid !== 1'b1 || delta !== 32'd4 || over_thresh !== 1'b1) begin
            errors++;
            $display("FAIL ar_first_report: valid=%b delta=%0d over=%b required 1/4/1",
                     valid, delta, over_thresh);
        end
        $display("test_async_reset: done");
    endtask

    task automatic test_enable_drop();
        go_idle();
        ready = 1'b0; thresh = 32'd100; sum_step = 32'd1;
        enable = 1'b1;
        for (int i = 0; i < 13; i++) step_cycle();
        enable = 1'b0;
        ready  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid !== 1'b1 || delta !== 32'd4 || count !== 3'(2 - k)) begin
                errors++;
                $display("FAIL ed_drain%0d: valid=%b delta=%0d count=%0d required 1/4/%0d",
                         k, valid, delta, count, 2 - k);
            end
            step_cycle();
        end
        checks++;
        if (valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL ed_empty: valid=%b count=%0d required 0/0", valid, count);
        end
        // Large jump while idle must not leak into the first new report.
        sum = sum + 32'd1000;
        sum_step = 32'd3;
        step_cycle();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) step_cycle();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL ed_reprime: valid=%b required 0", valid);
        end
        step_cycle();
        checks++;
        if (valid !== 1'b1 || delta !== 32'd12 || over_thresh !== 1'b0) begin
            errors++;
            $display("FAIL ed_first_report: valid=%b delta=%0d over=%b required 1/12/0",
                     valid, delta, over_thresh);
        end
        $display("test_enable_drop: done");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_threshold();
        test_wrap();
        test_backpressure();
        test_async_reset();
        test_enable_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
